// File: rtl/qspi_pkg.sv
// Shared quad-SPI definitions: command bytes, frame layout and the target FSM states.
// The controller side imports the same constants so both ends agree on the wire format.
package qspi_pkg;

  localparam logic [7:0] QSPI_CMD_READ     = 8'hEB;
  localparam logic [7:0] QSPI_CMD_WRITE    = 8'h38;
  localparam int         QSPI_ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_SKIP
  } qspi_state_t;

  // True for the command bytes this target knows how to serve.
  function automatic logic qspi_cmd_known(input logic [7:0] cmd);
    return (cmd == QSPI_CMD_READ) || (cmd == QSPI_CMD_WRITE);
  endfunction

endpackage

// File: rtl/qspi_mem_ram.sv
// Byte-wide single-port synchronous RAM, read-first, one-cycle read latency.
// Simulation harnesses may preload it by writing the r_mem array through its
// hierarchical name; the design itself never initialises contents.
module qspi_mem_ram #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;

  // One access per cycle: optional write plus a registered read of the same address
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/qspi_mem_target.sv
// Quad-SPI memory responder. Decodes quad read (0xEB) and quad write (0x38)
// frames clocked on the system clock and serves them from an internal byte RAM.
// Frame: command byte, 24-bit address, then DUMMY idle nibbles and read data,
// or write data directly. All fields travel high nibble first.
module qspi_mem_target
  import qspi_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DUMMY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic [3:0] dq_in,
  output logic [3:0] dq_out,
  output logic [3:0] dq_oe,
  output logic       busy,
  output logic       cmd_err
);

  qspi_state_t r_state;
  qspi_state_t w_next;

  logic [3:0]    r_cnt;       // address nibble index, then dummy edge index
  logic          r_half;      // 1: next data nibble is the low half of the byte
  logic          r_is_read;
  logic [23:0]   r_addr;
  logic [3:0]    r_cmd_hi;
  logic [3:0]    r_wr_hi;
  logic [3:0]    r_dq_out;
  logic [3:0]    r_dq_oe;
  logic          r_busy;
  logic          r_cmd_err;

  logic [7:0]    w_cmd;
  logic [23:0]   w_addr_full;
  logic          w_addr_last;
  logic          w_dummy_last;
  logic [AW-1:0] w_addr_inc;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [7:0]    w_ram_wdata;
  logic [7:0]    w_rdata;

  assign w_cmd        = {r_cmd_hi, dq_in};
  assign w_addr_full  = {r_addr[19:0], dq_in};
  assign w_addr_last  = (r_state == ST_ADDR) && (r_cnt == 4'(QSPI_ADDR_NIBBLES - 1));
  assign w_dummy_last = (r_cnt == 4'(DUMMY - 1));
  assign w_addr_inc   = r_addr[AW-1:0] + AW'(1);

  // State register; reset or any edge with cs_n high lands in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode from the current state and the nibble on the bus
  always_comb begin
    w_next = r_state;
    if (cs_n) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_CMD;
        ST_CMD:   w_next = qspi_cmd_known(w_cmd) ? ST_ADDR : ST_SKIP;
        ST_ADDR:  if (w_addr_last) w_next = r_is_read ? ST_DUMMY : ST_WDATA;
        ST_DUMMY: if (w_dummy_last) w_next = ST_RDATA;
        default:  w_next = r_state;
      endcase
    end
  end

  // RAM port steering: prefetch on the last address nibble and on every low
  // read nibble, write on every low write nibble (never with cs_n high)
  always_comb begin
    w_ram_addr  = r_addr[AW-1:0];
    w_ram_we    = 1'b0;
    w_ram_wdata = {r_wr_hi, dq_in};
    if (!cs_n) begin
      if (w_addr_last) begin
        w_ram_addr = w_addr_full[AW-1:0];
      end
      if ((r_state == ST_RDATA) && r_half) begin
        w_ram_addr = w_addr_inc;
      end
      if ((r_state == ST_WDATA) && r_half) begin
        w_ram_we = 1'b1;
      end
    end
  end

  // Counters, address, output registers and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_half    <= 1'b0;
      r_is_read <= 1'b0;
      r_addr    <= 24'd0;
      r_dq_out  <= 4'd0;
      r_dq_oe   <= 4'd0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_busy    <= (w_next != ST_IDLE);
      r_cmd_err <= !cs_n && (r_state == ST_CMD) && !qspi_cmd_known(w_cmd);
      r_dq_oe   <= 4'd0;
      r_dq_out  <= 4'd0;
      if (cs_n) begin
        r_cnt  <= 4'd0;
        r_half <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= 4'd0;
          end
          ST_CMD: begin
            r_is_read <= (w_cmd == QSPI_CMD_READ);
            r_cnt     <= 4'd0;
          end
          ST_ADDR: begin
            r_addr <= w_addr_full;
            r_half <= 1'b0;
            r_cnt  <= w_addr_last ? 4'd0 : r_cnt + 4'd1;
          end
          ST_DUMMY: begin
            r_cnt <= r_cnt + 4'd1;
            if (w_dummy_last) begin
              r_dq_oe  <= 4'hF;
              r_dq_out <= w_rdata[7:4];
              r_half   <= 1'b1;
            end
          end
          ST_RDATA: begin
            r_dq_oe <= 4'hF;
            if (r_half) begin
              r_dq_out         <= w_rdata[3:0];
              r_addr[AW-1:0]   <= w_addr_inc;
              r_half           <= 1'b0;
            end else begin
              r_dq_out <= w_rdata[7:4];
              r_half   <= 1'b1;
            end
          end
          ST_WDATA: begin
            if (r_half) begin
              r_addr[AW-1:0] <= w_addr_inc;
              r_half         <= 1'b0;
            end else begin
              r_half <= 1'b1;
            end
          end
          default: begin
            r_cnt <= r_cnt;
          end
        endcase
      end
    end
  end

  // Byte assembly holders; contents are only meaningful inside a frame
  always_ff @(posedge clk) begin
    if (!cs_n && (r_state == ST_IDLE)) begin
      r_cmd_hi <= dq_in;
    end
    if (!cs_n && (r_state == ST_WDATA) && !r_half) begin
      r_wr_hi <= dq_in;
    end
  end

  qspi_mem_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  assign dq_out  = r_dq_out;
  assign dq_oe   = r_dq_oe;
  assign busy    = r_busy;
  assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_qspi_mem_target.sv
// Bench for qspi_mem_target: drives quad-SPI frames edge by edge, predicts every
// output from the frame rules and a byte-level memory image, and pins the model
// with a few hand-computed nibble sequences.
module tb_qspi_mem_target;
  localparam int AW    = 16;
  localparam int DUMMY = 4;
  localparam int MASK  = (1 << AW) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic [3:0] dq_in;
  logic [3:0] dq_out;
  logic [3:0] dq_oe;
  logic       busy;
  logic       cmd_err;

  qspi_mem_target #(.AW(AW), .DUMMY(DUMMY)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_n    (cs_n),
    .dq_in   (dq_in),
    .dq_out  (dq_out),
    .dq_oe   (dq_oe),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;

  bit [7:0]   mm [int];   // known RAM bytes
  logic [3:0] wq [$];     // write nibbles for the next frame
  logic [3:0] rd_q [$];   // nibbles the controller would sample

  logic       exp_busy, exp_err, exp_oe, exp_out_vld;
  logic [3:0] exp_out;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_idle();
    exp_busy = 1'b0; exp_err = 1'b0; exp_oe = 1'b0; exp_out_vld = 1'b0; exp_out = 4'd0;
  endtask

  // Compare process: outputs are stable mid-cycle, check them on every falling edge
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(exp_busy));
    chk("cmd_err", int'(cmd_err), int'(exp_err));
    chk("dq_oe", int'(dq_oe), exp_oe ? 15 : 0);
    if (exp_oe && exp_out_vld) chk("dq_out", int'(dq_out), int'(exp_out));
    if (cmd_err) err_pulses++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      cs_n = 1'b1;
      dq_in = 4'($urandom);
      @(posedge clk); #1;
      set_idle();
    end
  endtask

  task automatic set_wq(input logic [63:0] v, input int n);
    wq.delete();
    for (int i = n - 1; i >= 0; i--) wq.push_back(v[4*i +: 4]);
  endtask

  // One frame: 8 header edges plus n_tail data edges, then one cs_n-high edge.
  // rst_at >= 0 asserts reset just after that edge instead of ending normally.
  task automatic txn(input logic [7:0] cmd, input logic [23:0] addr, input int n_tail, input int rst_at);
    bit rd, wr, badc;
    logic [3:0] nib, hi;
    int j, a;
    bit [7:0] b;
    rd = (cmd == 8'hEB);
    wr = (cmd == 8'h38);
    badc = !rd && !wr;
    hi = 4'd0;
    rd_q.delete();
    for (int k = 0; k < 8 + n_tail; k++) begin
      if (k == 0) nib = cmd[7:4];
      else if (k == 1) nib = cmd[3:0];
      else if (k < 8) nib = addr[23 - 4*(k-2) -: 4];
      else if (wr) nib = wq[k-8];
      else nib = 4'($urandom);
      if (rd && k >= 8 + DUMMY) rd_q.push_back(dq_out);
      cs_n = 1'b0;
      dq_in = nib;
      @(posedge clk); #1;
      exp_busy = 1'b1;
      exp_err = badc && (k == 1);
      exp_oe = rd && (k >= 7 + DUMMY);
      exp_out_vld = 1'b0;
      if (exp_oe) begin
        j = k - (7 + DUMMY);
        a = (int'(addr) + j / 2) & MASK;
        if (mm.exists(a)) begin
          b = mm[a];
          exp_out_vld = 1'b1;
          exp_out = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
      end
      if (wr && k >= 8) begin
        if ((k - 8) % 2 == 0) hi = nib;
        else mm[(int'(addr) + (k - 8) / 2) & MASK] = {hi, nib};
      end
      if (k == rst_at) begin
        #1;
        reset = 1'b1;
        cs_n = 1'b1;
        set_idle();
        #1;
        chk("rst_dq_oe", int'(dq_oe), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
    end
    cs_n = 1'b1;
    dq_in = 4'($urandom);
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic chk_nibs(input string name, input logic [31:0] want, input int n);
    chk({name, "_count"}, rd_q.size(), n);
    for (int i = 0; i < n && i < rd_q.size(); i++)
      chk(name, int'(rd_q[i]), int'(want[4*(n-1-i) +: 4]));
  endtask

  initial begin
    int kind, nb, e0;
    logic [7:0]  c;
    logic [23:0] a;
    reset = 1'b1;
    cs_n = 1'b1;
    dq_in = 4'd0;
    set_idle();
    #1;
    chk("reset_dq_out", int'(dq_out), 0);
    chk("reset_dq_oe", int'(dq_oe), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cmd_err", int'(cmd_err), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // write A5 3C at 0x10, read it back
    set_wq(64'hA53C, 4);
    txn(8'h38, 24'h000010, 4, -1);
    idle(1);
    txn(8'hEB, 24'h000010, DUMMY + 4, -1);
    chk_nibs("rd_10", 32'hA53C, 4);

    // wrap at the top of the RAM, then an aliased address
    set_wq(64'h1122, 4);
    txn(8'h38, 24'h00FFFF, 4, -1);
    txn(8'hEB, 24'h00FFFF, DUMMY + 4, -1);
    chk_nibs("rd_wrap", 32'h1122, 4);
    txn(8'hEB, 24'h01FFFF, DUMMY + 4, -1);
    chk_nibs("rd_alias", 32'h1122, 4);

    // unknown command, then a normal read still works
    e0 = err_pulses;
    txn(8'h9F, 24'h000000, 6, -1);
    chk("err_pulses", err_pulses - e0, 1);
    txn(8'hEB, 24'h000010, DUMMY + 4, -1);
    chk_nibs("rd_after_err", 32'hA53C, 4);

    // dangling high nibble must not touch the following byte
    set_wq(64'h125A, 4);
    txn(8'h38, 24'h000020, 4, -1);
    set_wq(64'h774, 3);
    txn(8'h38, 24'h000020, 3, -1);
    txn(8'hEB, 24'h000020, DUMMY + 4, -1);
    chk_nibs("rd_dangle", 32'h775A, 4);

    // reset in the middle of read data; RAM keeps its contents
    txn(8'hEB, 24'h000010, DUMMY + 8, 13);
    idle(1);
    txn(8'hEB, 24'h000010, DUMMY + 4, -1);
    chk_nibs("rd_after_rst", 32'hA53C, 4);

    // back-to-back writes with a single cs_n-high cycle between them
    set_wq(64'hBEEF, 4);
    txn(8'h38, 24'h000030, 4, -1);
    set_wq(64'hCAFE, 4);
    txn(8'h38, 24'h000032, 4, -1);
    txn(8'hEB, 24'h000030, DUMMY + 8, -1);
    chk_nibs("rd_b2b", 32'hBEEFCAFE, 8);

    // randomized frames against the model
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) a = {8'($urandom), 16'hFFF8 + 16'($urandom_range(0, 7))};
      else a = {8'($urandom), 16'h0100 + 16'($urandom_range(0, 31))};
      if (kind < 4) begin
        nb = 2 * $urandom_range(0, 5) + $urandom_range(0, 1);
        wq.delete();
        repeat (nb) wq.push_back(4'($urandom));
        txn(8'h38, a, nb, -1);
      end else if (kind < 9) begin
        txn(8'hEB, a, $urandom_range(0, DUMMY + 13), -1);
      end else begin
        do c = 8'($urandom); while (c == 8'hEB || c == 8'h38);
        txn(c, a, $urandom_range(0, 8), -1);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
